// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller beside ID: RAW stalls from an in-flight destination
// scoreboard, redirect flushes, and the multi-cycle memory-indirect jump sequence.
module pipe_hazard_ctrl #(
  parameter int DEPTH       = 2,
  parameter int JMEM_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [5:0]  id_rs,
  input  logic [5:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic [5:0]  id_rd,
  input  logic        id_regwrite,
  input  logic        id_jump_mem,
  input  logic        id_redirect,
  output logic        pc_we,
  output logic        pc_sel_mem,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
);

  localparam logic [0:0] RUN       = 1'b0;
  localparam logic [0:0] JMEM_WAIT = 1'b1;
  localparam logic [3:0] JMEM_LOAD = 4'(JMEM_CYCLES);

  logic [0:0]       state;
  logic [0:0]       state_next;
  logic [3:0]       jcnt;
  logic [3:0]       jcnt_next;
  logic [DEPTH-1:0] sb_v;
  logic [5:0]       sb_rd [DEPTH];
  logic             match_rs;
  logic             match_rt;
  logic             raw;
  logic             stall_inc;
  logic             flush_inc;
  logic             sb_insert;

  // Entry k holds the destination of the instruction k stages past ID.
  always_comb begin
    match_rs = 1'b0;
    match_rt = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (sb_v[k] && (sb_rd[k] == id_rs)) match_rs = 1'b1;
      if (sb_v[k] && (sb_rd[k] == id_rt)) match_rt = 1'b1;
    end
  end

  assign raw       = id_valid & ((id_uses_rs & match_rs) | (id_uses_rt & match_rt));
  assign sb_insert = id_valid & id_regwrite & ~idex_bubble;

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    pc_we       = 1'b0;
    pc_sel_mem  = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    state_next  = state;
    jcnt_next   = jcnt;

    if (reset) begin
      ifid_we     = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (raw) begin
            idex_bubble = 1'b1;
            stall_inc   = 1'b1;
          end else if (id_jump_mem) begin
            ifid_we    = 1'b1;
            ifid_flush = 1'b1;
            flush_inc  = 1'b1;
            jcnt_next  = JMEM_LOAD;
            state_next = JMEM_WAIT;
          end else if (id_valid && id_redirect) begin
            pc_we      = 1'b1;
            ifid_we    = 1'b1;
            ifid_flush = 1'b1;
            flush_inc  = 1'b1;
          end else begin
            pc_we   = 1'b1;
            ifid_we = 1'b1;
          end
        end
        JMEM_WAIT: begin
          idex_bubble = 1'b1;
          ifid_we     = 1'b1;
          ifid_flush  = 1'b1;
          stall_inc   = 1'b1;
          jcnt_next   = jcnt - 4'd1;
          // Last wait cycle: data_mem_out now carries the jump target.
          if (jcnt == 4'd1) begin
            pc_we      = 1'b1;
            pc_sel_mem = 1'b1;
            state_next = RUN;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      jcnt         <= 4'd0;
      sb_v         <= '0;
      stall_cycles <= 16'd0;
      flush_count  <= 16'd0;
    end else begin
      state <= state_next;
      jcnt  <= jcnt_next;
      for (int k = DEPTH - 1; k > 0; k--) sb_v[k] <= sb_v[k-1];
      sb_v[0] <= sb_insert;
      if (stall_inc && (stall_cycles != 16'hFFFF)) stall_cycles <= stall_cycles + 16'd1;
      if (flush_inc && (flush_count != 16'hFFFF)) flush_count <= flush_count + 16'd1;
    end
  end

  // NOTE: register tags are not reset; a tag is only looked at when its valid bit is set.
  always_ff @(posedge clk) begin
    for (int k = DEPTH - 1; k > 0; k--) sb_rd[k] <= sb_rd[k-1];
    sb_rd[0] <= id_rd;
  end

endmodule
